// File: rtl/mul_sequencer_if.sv
// Start/busy/done handshake and result bus between the core control FSM and mul_sequencer.
interface mul_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [1:0]       flags;
    logic             long_op;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags, long_op
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags, long_op
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add sequencer for MUL/UMULL/SMULL with start/busy/done handshake.
// Optional macro MUL_SEQ_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier is zero.
module mul_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);

    localparam int unsigned PW       = 2 * WIDTH;
    localparam logic [1:0]  OP_MUL   = 2'b00;
    localparam logic [1:0]  OP_SMULL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_res_q, neg_res_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_lo_q, result_lo_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [1:0]         flags_q, flags_d;
    logic               long_op_q, long_op_d;

    logic [WIDTH-1:0]   a_abs_c;
    logic [WIDTH-1:0]   b_abs_c;
    logic [PW-1:0]      partial_c;
    logic [WIDTH-1:0]   mplier_nxt_c;
    logic               last_step_c;
    logic [PW-1:0]      acc_fix_c;

    // Magnitudes for SMULL; the most negative value maps onto itself, which is the right unsigned magnitude.
    assign a_abs_c = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_abs_c = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

    assign partial_c    = PW'(mcand_q) << count_q;
    assign mplier_nxt_c = mplier_q >> 1;
    assign acc_fix_c    = neg_res_q ? (~acc_q + PW'(1)) : acc_q;

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign last_step_c = (count_q == CNT_W'(WIDTH - 1)) || (mplier_nxt_c == '0);
`else
    assign last_step_c = (count_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_res_q   <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            long_op_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_res_q   <= neg_res_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            long_op_q   <= long_op_d;
        end
    end

    // Next-state and datapath updates; busy/done are computed one cycle ahead so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_res_d   = neg_res_q;
        acc_d       = acc_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        long_op_d   = long_op_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                    if (bus.op == OP_SMULL) begin
                        mcand_d   = a_abs_c;
                        mplier_d  = b_abs_c;
                        neg_res_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_d   = bus.a;
                        mplier_d  = bus.b;
                        neg_res_d = 1'b0;
                    end
                end
            end

            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + partial_c;
                end
                mplier_d = mplier_nxt_c;
                count_d  = count_q + CNT_W'(1);
                if (last_step_c) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                acc_d       = acc_fix_c;
                result_lo_d = acc_fix_c[WIDTH-1:0];
                long_op_d   = (op_q != OP_MUL);
                if (op_q == OP_MUL) begin
                    result_hi_d = '0;
                    flags_d     = {acc_fix_c[WIDTH-1], (acc_fix_c[WIDTH-1:0] == '0)};
                end else begin
                    result_hi_d = acc_fix_c[PW-1:WIDTH];
                    flags_d     = {acc_fix_c[PW-1], (acc_fix_c == '0)};
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = result_lo_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.long_op   = long_op_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer; latencies follow MUL_SEQ_EARLY_TERM_EN when defined.
module tb_mul_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
`ifdef MUL_SEQ_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation once the unit is idle; lat is the cycle count from start sample to done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int guard;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h1357_9BDF; bus.op = 2'b10;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b1; bus.op = OP_UMULL; bus.a = 32'd3; bus.b = 32'd4;
        @(posedge clk); @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'd0) begin bad++; $display("FAIL rst_result got=%h want=0", {bus.result_hi, bus.result_lo}); end
        total++; if ({bus.flags, bus.long_op} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {bus.flags, bus.long_op}); end
        reset = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_start_ignored busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_mul();
        int lat;
        run_op(OP_MUL, 32'd7, 32'd6, lat);
        total++; if (lat !== (ET ? 5 : 34)) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", lat, ET ? 5 : 34); end
        total++; if (bus.result_lo !== 32'd42) begin bad++; $display("FAIL mul_lo got=%h want=2a", bus.result_lo); end
        total++; if (bus.result_hi !== 32'd0) begin bad++; $display("FAIL mul_hi got=%h want=0", bus.result_hi); end
        total++; if ({bus.flags, bus.long_op} !== 3'b000) begin bad++; $display("FAIL mul_flags got=%b want=000", {bus.flags, bus.long_op}); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mul_busy_at_done got=%b want=1", bus.busy); end
        @(posedge clk); #1;
        total++; if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL mul_done_pulse got=%b want=00", {bus.done, bus.busy}); end
        repeat (3) @(posedge clk); #1;
        total++; if (bus.result_lo !== 32'd42) begin bad++; $display("FAIL mul_hold got=%h want=2a", bus.result_lo); end
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        total++; if ({bus.result_hi, bus.result_lo} !== 64'h0000_0000_0000_0001) begin bad++; $display("FAIL mul_hi_forced got=%h want=1", {bus.result_hi, bus.result_lo}); end
    endtask

    task automatic test_umull();
        int lat;
        run_op(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL umull_latency got=%0d want=34", lat); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL umull_result got=%h want=fffffffe00000001", {bus.result_hi, bus.result_lo}); end
        total++; if ({bus.flags, bus.long_op} !== 3'b101) begin bad++; $display("FAIL umull_flags got=%b want=101", {bus.flags, bus.long_op}); end
        run_op(2'b11, 32'h8000_0000, 32'd2, lat);
        total++; if ({bus.result_hi, bus.result_lo, bus.long_op} !== {64'h0000_0001_0000_0000, 1'b1}) begin bad++; $display("FAIL reserved_op got=%h_%h lo=%b want=0000000100000000 1", bus.result_hi, bus.result_lo, bus.long_op); end
    endtask

    task automatic test_smull();
        int lat;
        run_op(OP_SMULL, 32'hFFFF_FFFE, 32'd3, lat);
        total++; if (lat !== (ET ? 4 : 34)) begin bad++; $display("FAIL smull_neg_latency got=%0d want=%0d", lat, ET ? 4 : 34); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("FAIL smull_neg_result got=%h want=fffffffffffffffa", {bus.result_hi, bus.result_lo}); end
        total++; if ({bus.flags, bus.long_op} !== 3'b101) begin bad++; $display("FAIL smull_neg_flags got=%b want=101", {bus.flags, bus.long_op}); end
        run_op(OP_SMULL, 32'h8000_0000, 32'h8000_0000, lat);
        total++; if ({bus.result_hi, bus.result_lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL smull_min_result got=%h want=4000000000000000", {bus.result_hi, bus.result_lo}); end
        total++; if (bus.flags !== 2'b00) begin bad++; $display("FAIL smull_min_flags got=%b want=00", bus.flags); end
        run_op(OP_SMULL, 32'd5, 32'hFFFF_FFFD, lat);
        total++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL smull_mixed got=%h want=fffffffffffffff1", {bus.result_hi, bus.result_lo}); end
        run_op(OP_SMULL, 32'hFFFF_FFF9, 32'hFFFF_FFFA, lat);
        total++; if ({bus.result_hi, bus.result_lo, bus.flags} !== {64'd42, 2'b00}) begin bad++; $display("FAIL smull_negneg got=%h_%h f=%b want=42 00", bus.result_hi, bus.result_lo, bus.flags); end
    endtask

    task automatic test_busy_ignored();
        int cyc;
        int ndone;
        int first;
        logic [63:0] res;
        logic [2:0]  fl;
        while (bus.busy) begin @(posedge clk); #1; end
        bus.op = OP_UMULL; bus.a = 32'd0; bus.b = 32'h1234_5678; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0; first = 0; res = '1; fl = '1;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (bus.done) begin
                ndone++;
                if (first == 0) begin
                    first = cyc; res = {bus.result_hi, bus.result_lo}; fl = {bus.flags, bus.long_op};
                end
            end
            if (cyc == 5 || cyc == 20) begin
                bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        total++; if (ndone !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", ndone); end
        total++; if (first !== (ET ? 31 : 34)) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", first, ET ? 31 : 34); end
        total++; if (res !== 64'd0) begin bad++; $display("FAIL zero_result got=%h want=0", res); end
        total++; if (fl !== 3'b011) begin bad++; $display("FAIL zero_flags got=%b want=011", fl); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        while (bus.busy) begin @(posedge clk); #1; end
        bus.op = OP_UMULL; bus.a = 32'd3; bus.b = 32'hF000_0000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL midrst_handshake got=%b want=00", {bus.busy, bus.done}); end
        total++; if ({bus.result_hi, bus.result_lo, bus.flags, bus.long_op} !== 67'd0) begin bad++; $display("FAIL midrst_results got=%h_%h want=0", bus.result_hi, bus.result_lo); end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
        run_op(OP_MUL, 32'd7, 32'd6, lat);
        total++; if ({lat, bus.result_lo} !== {ET ? 32'd5 : 32'd34, 32'd42}) begin bad++; $display("FAIL midrst_restart lat=%0d lo=%h want lat=%0d lo=2a", lat, bus.result_lo, ET ? 5 : 34); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(OP_UMULL, 32'd3, 32'd5, lat);
        total++; if ({bus.result_lo, bus.long_op} !== {32'd15, 1'b1}) begin bad++; $display("FAIL b2b_first got=%h/%b want=f/1", bus.result_lo, bus.long_op); end
        bus.op = OP_MUL; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        @(posedge clk); #1;
        total++; if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL b2b_start_in_done got=%b want=00", {bus.busy, bus.done}); end
        total++; if ({bus.result_lo, bus.long_op} !== {32'd15, 1'b1}) begin bad++; $display("FAIL b2b_hold got=%h/%b want=f/1", bus.result_lo, bus.long_op); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", bus.busy); end
        lat = 1;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== (ET ? 6 : 34)) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, ET ? 6 : 34); end
        total++; if ({bus.result_hi, bus.result_lo, bus.long_op} !== {32'd0, 32'd81, 1'b0}) begin bad++; $display("FAIL b2b_second got=%h_%h/%b want=0_51/0", bus.result_hi, bus.result_lo, bus.long_op); end
    endtask

    task automatic test_early_term();
        int lat;
        run_op(OP_MUL, 32'd5, 32'd1, lat);
        total++; if (lat !== (ET ? 3 : 34)) begin bad++; $display("FAIL et_b1_latency got=%0d want=%0d", lat, ET ? 3 : 34); end
        total++; if (bus.result_lo !== 32'd5) begin bad++; $display("FAIL et_b1_lo got=%h want=5", bus.result_lo); end
        run_op(OP_MUL, 32'd5, 32'h8000_0000, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL et_msb_latency got=%0d want=34", lat); end
        total++; if ({bus.result_hi, bus.result_lo, bus.flags} !== {32'd0, 32'h8000_0000, 2'b10}) begin bad++; $display("FAIL et_msb_result got=%h_%h f=%b want=0_80000000 10", bus.result_hi, bus.result_lo, bus.flags); end
        run_op(OP_UMULL, 32'h1234_5678, 32'd0, lat);
        total++; if ({lat, bus.flags} !== {ET ? 32'd3 : 32'd34, 2'b01}) begin bad++; $display("FAIL et_b0 lat=%0d f=%b want lat=%0d f=01", lat, bus.flags, ET ? 3 : 34); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        test_reset();
        test_mul();
        test_umull();
        test_smull();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        test_early_term();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
